// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and the shared memory port for mem_port_arbiter.
// The slave view is the arbiter itself; the master view is the surrounding
// environment (both requesters plus the memory that answers mem_addr).
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          owner;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single unified memory port.
// Master 0 is the CPU controller path, master 1 the loader/DMA port.
// Each access runs IDLE -> ACCESS (WAIT+1 cycles) -> DONE, with the request
// fields latched on grant so the memory side never sees requester glitches.
module mem_port_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_C = 3'(WAIT);

    state_t        state_r;
    logic [2:0]    cnt_r;
    logic          owner_r;
    logic          last_owner_r;
    logic          we_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic          mem_en_r;
    logic          mem_we_r;
    logic          busy_r;
    logic          m0_ack_r;
    logic          m1_ack_r;
    logic [DW-1:0] m0_rdata_r;
    logic [DW-1:0] m1_rdata_r;

    logic          grant_valid_s;
    logic          grant_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;

    // Round-robin choice: on a tie the master that did not own the port last wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            grant_valid_s = 1'b1;
            grant_s       = ~last_owner_r;
        end else if (bus.m1_req) begin
            grant_valid_s = 1'b1;
            grant_s       = 1'b1;
        end else if (bus.m0_req) begin
            grant_valid_s = 1'b1;
            grant_s       = 1'b0;
        end else begin
            grant_valid_s = 1'b0;
            grant_s       = 1'b0;
        end
    end

    // Route the winning master's request fields toward the latch registers.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {AW{1'b0}};
        sel_wdata_s = {DW{1'b0}};
        if (grant_s) begin
            sel_we_s    = bus.m1_we;
            sel_addr_s  = bus.m1_addr;
            sel_wdata_s = bus.m1_wdata;
        end else begin
            sel_we_s    = bus.m0_we;
            sel_addr_s  = bus.m0_addr;
            sel_wdata_s = bus.m0_wdata;
        end
    end

    // Access sequencer: grant/latch in IDLE, count waits in ACCESS, ack in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 3'd0;
            owner_r      <= 1'b0;
            last_owner_r <= 1'b1;
            we_r         <= 1'b0;
            addr_r       <= {AW{1'b0}};
            wdata_r      <= {DW{1'b0}};
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            busy_r       <= 1'b0;
            m0_ack_r     <= 1'b0;
            m1_ack_r     <= 1'b0;
            m0_rdata_r   <= {DW{1'b0}};
            m1_rdata_r   <= {DW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    m0_ack_r <= 1'b0;
                    m1_ack_r <= 1'b0;
                    if (grant_valid_s) begin
                        owner_r  <= grant_s;
                        we_r     <= sel_we_s;
                        addr_r   <= sel_addr_s;
                        wdata_r  <= sel_wdata_s;
                        cnt_r    <= WAIT_C;
                        mem_en_r <= 1'b1;
                        // With no wait states the first ACCESS cycle is also the last.
                        mem_we_r <= sel_we_s && (WAIT_C == 3'd0);
                        busy_r   <= 1'b1;
                        state_r  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_r == 3'd0) begin
                        mem_en_r     <= 1'b0;
                        mem_we_r     <= 1'b0;
                        last_owner_r <= owner_r;
                        state_r      <= ST_DONE;
                        if (owner_r) begin
                            m1_ack_r <= 1'b1;
                            if (!we_r) begin
                                m1_rdata_r <= bus.mem_rdata;
                            end
                        end else begin
                            m0_ack_r <= 1'b1;
                            if (!we_r) begin
                                m0_rdata_r <= bus.mem_rdata;
                            end
                        end
                    end else begin
                        cnt_r    <= cnt_r - 3'd1;
                        // Strobe only in the cycle where the counter will read zero.
                        mem_we_r <= we_r && (cnt_r == 3'd1);
                    end
                end
                ST_DONE: begin
                    m0_ack_r <= 1'b0;
                    m1_ack_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                    m0_ack_r <= 1'b0;
                    m1_ack_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.m0_ack    = m0_ack_r;
    assign bus.m1_ack    = m1_ack_r;
    assign bus.m0_rdata  = m0_rdata_r;
    assign bus.m1_rdata  = m1_rdata_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.busy      = busy_r;
    assign bus.owner     = owner_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances (WAIT = 1, 2, 0) share
// one stimulus set; each scenario checks the instance whose wait count it targets.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [31:0] mem_rd_val;

    int n_tests;
    int n_fail;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

        assign bus.m0_req    = m0_req;
        assign bus.m0_we     = m0_we;
        assign bus.m0_addr   = m0_addr;
        assign bus.m0_wdata  = m0_wdata;
        assign bus.m1_req    = m1_req;
        assign bus.m1_we     = m1_we;
        assign bus.m1_addr   = m1_addr;
        assign bus.m1_wdata  = m1_wdata;
        assign bus.mem_rdata = mem_rd_val;

        mem_port_arbiter #(
            .AW   (32),
            .DW   (32),
            .WAIT ((g == 0) ? 1 : ((g == 1) ? 2 : 0))
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        m0_req     = 1'b0;
        m0_we      = 1'b0;
        m0_addr    = 32'h0;
        m0_wdata   = 32'h0;
        m1_req     = 1'b0;
        m1_we      = 1'b0;
        m1_addr    = 32'h0;
        m1_wdata   = 32'h0;
        mem_rd_val = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        n_tests = 0;
        n_fail  = 0;

        // ---- Reset values ----
        do_reset();
        check("rst_m0_ack",    64'(g_dut[0].bus.m0_ack),    64'h0);
        check("rst_m1_ack",    64'(g_dut[0].bus.m1_ack),    64'h0);
        check("rst_mem_en",    64'(g_dut[0].bus.mem_en),    64'h0);
        check("rst_mem_we",    64'(g_dut[0].bus.mem_we),    64'h0);
        check("rst_mem_addr",  64'(g_dut[0].bus.mem_addr),  64'h0);
        check("rst_mem_wdata", 64'(g_dut[0].bus.mem_wdata), 64'h0);
        check("rst_m0_rdata",  64'(g_dut[0].bus.m0_rdata),  64'h0);
        check("rst_m1_rdata",  64'(g_dut[0].bus.m1_rdata),  64'h0);
        check("rst_busy",      64'(g_dut[0].bus.busy),      64'h0);
        check("rst_owner",     64'(g_dut[0].bus.owner),     64'h0);
        check("rst_busy_w2",   64'(g_dut[1].bus.busy),      64'h0);
        check("rst_busy_w0",   64'(g_dut[2].bus.busy),      64'h0);

        // ---- m0 read of 0x10, WAIT=1: ACCESS cycles 1-2, ack cycle 3 ----
        m0_req     = 1'b1;
        m0_we      = 1'b0;
        m0_addr    = 32'h10;
        mem_rd_val = 32'hDEADBEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("rd_mem_en", 64'(g_dut[0].bus.mem_en), 64'((c == 1) || (c == 2)));
            check("rd_mem_we", 64'(g_dut[0].bus.mem_we), 64'h0);
            check("rd_m0_ack", 64'(g_dut[0].bus.m0_ack), 64'(c == 3));
            check("rd_m1_ack", 64'(g_dut[0].bus.m1_ack), 64'h0);
            check("rd_busy",   64'(g_dut[0].bus.busy),   64'((c >= 1) && (c <= 3)));
            if (c == 1) begin
                check("rd_mem_addr", 64'(g_dut[0].bus.mem_addr), 64'h10);
            end
            if (c == 3) begin
                check("rd_m0_rdata", 64'(g_dut[0].bus.m0_rdata), 64'hDEADBEEF);
                m0_req = 1'b0;
            end
        end

        // ---- m1 read then write of 0x55AA to 0x20, WAIT=2 ----
        do_reset();
        m1_req     = 1'b1;
        m1_we      = 1'b0;
        m1_addr    = 32'h30;
        mem_rd_val = 32'h0000ABCD;
        repeat (4) tick();
        check("w2_rd_ack",    64'(g_dut[1].bus.m1_ack),   64'h1);
        check("w2_rd_rdata",  64'(g_dut[1].bus.m1_rdata), 64'h0000ABCD);
        m1_req = 1'b0;
        tick();
        m1_req     = 1'b1;
        m1_we      = 1'b1;
        m1_addr    = 32'h20;
        m1_wdata   = 32'h000055AA;
        mem_rd_val = 32'h99999999;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("wr_mem_en", 64'(g_dut[1].bus.mem_en), 64'((c >= 1) && (c <= 3)));
            check("wr_mem_we", 64'(g_dut[1].bus.mem_we), 64'(c == 3));
            check("wr_m1_ack", 64'(g_dut[1].bus.m1_ack), 64'(c == 4));
            check("wr_m0_ack", 64'(g_dut[1].bus.m0_ack), 64'h0);
            if (c == 3) begin
                check("wr_mem_addr",  64'(g_dut[1].bus.mem_addr),  64'h20);
                check("wr_mem_wdata", 64'(g_dut[1].bus.mem_wdata), 64'h55AA);
            end
            if (c == 4) begin
                m1_req = 1'b0;
            end
        end
        check("wr_m1_rdata_kept", 64'(g_dut[1].bus.m1_rdata), 64'h0000ABCD);

        // ---- Both masters requesting continuously, WAIT=1: period 4 ----
        do_reset();
        m0_req     = 1'b1;
        m0_we      = 1'b0;
        m0_addr    = 32'h100;
        m1_req     = 1'b1;
        m1_we      = 1'b0;
        m1_addr    = 32'h200;
        mem_rd_val = 32'h12345678;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("rr_m0_ack", 64'(g_dut[0].bus.m0_ack), 64'((c == 3) || (c == 11)));
            check("rr_m1_ack", 64'(g_dut[0].bus.m1_ack), 64'((c == 7) || (c == 15)));
            check("rr_owner",  64'(g_dut[0].bus.owner),  64'(((c - 1) / 4) % 2));
        end
        m0_req = 1'b0;
        m1_req = 1'b0;

        // ---- Read-data retention per master, WAIT=1 ----
        do_reset();
        m0_req     = 1'b1;
        m0_we      = 1'b0;
        m0_addr    = 32'h40;
        mem_rd_val = 32'h1111;
        repeat (3) tick();
        check("ret_m0_ack1",  64'(g_dut[0].bus.m0_ack),   64'h1);
        check("ret_m0_rd1",   64'(g_dut[0].bus.m0_rdata), 64'h1111);
        m0_req = 1'b0;
        tick();
        m1_req     = 1'b1;
        m1_we      = 1'b0;
        m1_addr    = 32'h44;
        mem_rd_val = 32'h2222;
        repeat (3) tick();
        check("ret_m1_ack",   64'(g_dut[0].bus.m1_ack),   64'h1);
        check("ret_m1_rd",    64'(g_dut[0].bus.m1_rdata), 64'h2222);
        check("ret_m0_rd2",   64'(g_dut[0].bus.m0_rdata), 64'h1111);
        m1_req = 1'b0;
        tick();
        m0_req     = 1'b1;
        m0_we      = 1'b1;
        m0_addr    = 32'h48;
        m0_wdata   = 32'h4444;
        mem_rd_val = 32'h3333;
        repeat (3) tick();
        check("ret_m0_ack2",  64'(g_dut[0].bus.m0_ack),   64'h1);
        check("ret_m0_rd3",   64'(g_dut[0].bus.m0_rdata), 64'h1111);
        m0_req = 1'b0;

        // ---- Input changes during ACCESS, WAIT=1 ----
        do_reset();
        m0_req   = 1'b1;
        m0_we    = 1'b1;
        m0_addr  = 32'h50;
        m0_wdata = 32'hAAAA;
        tick();
        check("chg_addr_c1", 64'(g_dut[0].bus.mem_addr), 64'h50);
        m0_addr  = 32'h60;
        m0_wdata = 32'hBBBB;
        m0_req   = 1'b0;
        tick();
        check("chg_addr_c2",  64'(g_dut[0].bus.mem_addr),  64'h50);
        check("chg_wdata_c2", 64'(g_dut[0].bus.mem_wdata), 64'hAAAA);
        check("chg_we_c2",    64'(g_dut[0].bus.mem_we),    64'h1);
        tick();
        check("chg_ack_c3",   64'(g_dut[0].bus.m0_ack),    64'h1);
        tick();
        check("chg_ack_c4",   64'(g_dut[0].bus.m0_ack),    64'h0);
        tick();
        check("chg_busy_c5",  64'(g_dut[0].bus.busy),      64'h0);

        // ---- Reset in the final ACCESS cycle of an m1 write, WAIT=0 ----
        do_reset();
        m1_req   = 1'b1;
        m1_we    = 1'b1;
        m1_addr  = 32'h70;
        m1_wdata = 32'h7777;
        tick();
        check("ar_we_before",    64'(g_dut[2].bus.mem_we), 64'h1);
        check("ar_owner_before", 64'(g_dut[2].bus.owner),  64'h1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_mem_we",    64'(g_dut[2].bus.mem_we),    64'h0);
        check("ar_mem_en",    64'(g_dut[2].bus.mem_en),    64'h0);
        check("ar_busy",      64'(g_dut[2].bus.busy),      64'h0);
        check("ar_owner",     64'(g_dut[2].bus.owner),     64'h0);
        check("ar_mem_addr",  64'(g_dut[2].bus.mem_addr),  64'h0);
        check("ar_mem_wdata", 64'(g_dut[2].bus.mem_wdata), 64'h0);
        tick();
        check("ar_no_ack",    64'(g_dut[2].bus.m1_ack),    64'h0);
        rst     = 1'b0;
        m0_req  = 1'b1;
        m0_we   = 1'b0;
        m0_addr = 32'h80;
        tick();
        check("ar_tie_owner", 64'(g_dut[2].bus.owner),    64'h0);
        check("ar_tie_addr",  64'(g_dut[2].bus.mem_addr), 64'h80);
        check("ar_tie_m1ack", 64'(g_dut[2].bus.m1_ack),   64'h0);
        tick();
        check("ar_tie_m0ack", 64'(g_dut[2].bus.m0_ack),   64'h1);
        check("ar_tie_m1ack2", 64'(g_dut[2].bus.m1_ack),  64'h0);
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
